forwarding_ctrl: RTL
====================

// Module: forwarding_ctrl
// PURPOSE
//  Drives the 2-bit select inputs of the EX-stage 3:1 operand muxes (A and B) of the 64-bit pipeline.
//  - Holds its own shadow pipeline of destination-register info: ID/EX -> EX/MEM -> MEM/WB.
//  - Resolves RAW hazards by forwarding, and detects load-use hazards that need a 1-cycle stall.
//  - Sits beside the ID/EX pipeline register. Its only datapath coupling is the select codes.
// PARAMETERS
//  REG_AW  5   architectural register index width (x0..x31)
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-low reset
//  id_rs1        in   REG_AW  source reg 1 of the instruction in ID
//  id_rs2        in   REG_AW  source reg 2 of the instruction in ID
//  id_rd         in   REG_AW  destination reg of the instruction in ID
//  id_regwrite   in   1       instruction in ID writes rd
//  id_memread    in   1       instruction in ID is a load
//  flush         in   1       taken branch: the ID instruction is squashed into ID/EX
//  forward_a     out  2       select for operand-A mux
//  forward_b     out  2       select for operand-B mux
//  load_stall    out  1       hold PC and IF/ID this cycle
// BEHAVIOUR
//  Select encoding (fixed, matches mux inputs):
//   - 2'b00: ID/EX register-file operand
//   - 2'b01: MEM/WB write-back data
//   - 2'b10: EX/MEM ALU result
//   - 2'b11: never driven
//  Shadow pipeline:
//   - Registers: idex{rs1,rs2,rd,regwrite,memread}, exmem{rd,regwrite,memread}, memwb{rd,regwrite}.
//   - Every clk with reset=1: exmem<=idex and memwb<=exmem, unconditionally.
//   - idex <= bubble (all fields 0) when flush | load_stall; otherwise idex <= id_* inputs.
//   - No pipeline freeze input. Back-to-back bubbles are allowed.
//  Forwarding (combinational from registered state; valid in the cycle the instruction is in EX):
//   - forward_a = 2'b10 if exmem.regwrite && exmem.rd!=0 && exmem.rd==idex.rs1
//   - else forward_a = 2'b01 if memwb.regwrite && memwb.rd!=0 && memwb.rd==idex.rs1
//   - else forward_a = 2'b00.
//   - forward_b: same rules, using idex.rs2.
//   - EX/MEM beats MEM/WB when both match (newest value wins). x0 is never forwarded.
//   - rs1==rs2 is legal: both selects then carry the same code.
//  Load-use stall (combinational):
//   - load_stall = idex.memread && idex.rd!=0 && (idex.rd==id_rs1 || idex.rd==id_rs2).
//   - Next edge inserts a bubble into idex. One cycle later the load is in EX/MEM; the following
//     cycle it reaches MEM/WB and the dependent instruction gets 2'b01.
//   - load_stall and flush together: flush wins, and the bubble is inserted once.
//  Reset:
//   - reset=0 at an edge clears every shadow register.
//   - Outputs then read forward_a=forward_b=2'b00 and load_stall=0, regardless of id_* inputs.
//   - Mid-operation reset discards all in-flight hazard state. No forwarding from pre-reset writes.
// CONFIGURATION
//  FWD_LOAD_STALL_EN
//   - Defined: load-use detection as above.
//   - Undefined: load_stall tied 0, idex.memread/exmem.memread removed, bubble only on flush.
//     The core must then schedule loads in software.
// TESTING
//  1. reset=0 for 2 clks with id_rs1=id_rd=3, id_regwrite=1
//     -> forward_a=forward_b=00, load_stall=0 throughout.
//  2. ADD x5 then SUB x6,x5,x5 back-to-back
//     -> SUB in EX: forward_a=forward_b=10.
//     -> ADD x5; NOP; SUB x6,x5,x1 gives forward_a=01, forward_b=00.
//  3. ADD x7; ADD x7; OR x8,x7,x0
//     -> OR in EX: forward_a=10 (newest wins), forward_b=00 (x0 never forwarded).
//  4. LD x9 then ADD x10,x9,x2 (FWD_LOAD_STALL_EN)
//     -> load_stall=1 for exactly 1 cycle; bubble in EX; ADD in EX gets forward_a=01.
//  5. Writes to x0 (id_rd=0, regwrite=1) followed by a reader of x0
//     -> forward codes stay 00; no stall after LD x0.
//  6. flush=1 with LD x4 in EX and ID reading x4
//     -> single bubble, load_stall ignored; reset=0 mid-sequence clears all forwards next cycle.

Source files
------------

// File: rtl/forwarding_ctrl.sv
// EX-stage operand forwarding and load-use hazard control with a shadow ID/EX -> EX/MEM -> MEM/WB pipeline.
// Optional feature macro: FWD_LOAD_STALL_EN (load-use stall detection; undefined = load_stall tied 0).
module forwarding_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              load_stall
);

  localparam logic [1:0]        SEL_RF  = 2'b00;
  localparam logic [1:0]        SEL_WB  = 2'b01;
  localparam logic [1:0]        SEL_EXM = 2'b10;
  localparam logic [REG_AW-1:0] REG_X0  = '0;

  logic [REG_AW-1:0] r_idex_rs1_p0;
  logic [REG_AW-1:0] r_idex_rs2_p0;
  logic [REG_AW-1:0] r_idex_rd_p0;
  logic              r_idex_regwrite_p0;
  logic [REG_AW-1:0] r_exmem_rd_p1;
  logic              r_exmem_regwrite_p1;
  logic [REG_AW-1:0] r_memwb_rd_p2;
  logic              r_memwb_regwrite_p2;

  logic              w_load_stall;
  logic              w_bubble;
  logic              w_unused;

  // Newest producer wins; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] exm_rd,
    input logic              exm_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic              wb_we
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (exm_we && (exm_rd != REG_X0) && (exm_rd == src)) begin
      sel = SEL_EXM;
    end else if (wb_we && (wb_rd != REG_X0) && (wb_rd == src)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

`ifdef FWD_LOAD_STALL_EN
  logic r_idex_memread_p0;
  logic r_exmem_memread_p1;

  assign w_load_stall = r_idex_memread_p0 && (r_idex_rd_p0 != REG_X0) &&
                        ((r_idex_rd_p0 == id_rs1) || (r_idex_rd_p0 == id_rs2));
  assign w_unused     = r_exmem_memread_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idex_memread_p0  <= 1'b0;
      r_exmem_memread_p1 <= 1'b0;
    end else begin
      r_exmem_memread_p1 <= r_idex_memread_p0;
      r_idex_memread_p0  <= w_bubble ? 1'b0 : id_memread;
    end
  end
`else
  // Loads are scheduled by software in this build, so the load flag is not tracked.
  assign w_load_stall = 1'b0;
  assign w_unused     = id_memread;
`endif

  // A stall and a flush in the same cycle still produce exactly one bubble.
  assign w_bubble = flush | w_load_stall;

  // ID -> ID/EX (_p0) -> EX/MEM (_p1) -> MEM/WB (_p2)
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idex_rs1_p0       <= '0;
      r_idex_rs2_p0       <= '0;
      r_idex_rd_p0        <= '0;
      r_idex_regwrite_p0  <= 1'b0;
      r_exmem_rd_p1       <= '0;
      r_exmem_regwrite_p1 <= 1'b0;
      r_memwb_rd_p2       <= '0;
      r_memwb_regwrite_p2 <= 1'b0;
    end else begin
      r_memwb_rd_p2       <= r_exmem_rd_p1;
      r_memwb_regwrite_p2 <= r_exmem_regwrite_p1;
      r_exmem_rd_p1       <= r_idex_rd_p0;
      r_exmem_regwrite_p1 <= r_idex_regwrite_p0;
      if (w_bubble) begin
        r_idex_rs1_p0      <= '0;
        r_idex_rs2_p0      <= '0;
        r_idex_rd_p0       <= '0;
        r_idex_regwrite_p0 <= 1'b0;
      end else begin
        r_idex_rs1_p0      <= id_rs1;
        r_idex_rs2_p0      <= id_rs2;
        r_idex_rd_p0       <= id_rd;
        r_idex_regwrite_p0 <= id_regwrite;
      end
    end
  end

  // EX-stage mux selects
  assign forward_a  = fwd_sel(r_idex_rs1_p0, r_exmem_rd_p1, r_exmem_regwrite_p1,
                              r_memwb_rd_p2, r_memwb_regwrite_p2);
  assign forward_b  = fwd_sel(r_idex_rs2_p0, r_exmem_rd_p1, r_exmem_regwrite_p1,
                              r_memwb_rd_p2, r_memwb_regwrite_p2);
  assign load_stall = w_load_stall;

endmodule
